io_bus_arbiter: RTL and testbench

IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

---
 rtl/io_bus_pkg.sv | 20 ++
 rtl/io_rr_pick.sv | 26 ++
 rtl/io_bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_io_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_pkg.sv
// io_bus_pkg: shared types and constants for the two-master IO bus arbiter.
//   state_t              : arbiter FSM states
//   TIMEOUT_CYCLES_DEF   : default bus_ready wait limit in cycles
//   ERR_RDATA_DEF        : default read data returned on a timeout
//   MASTER_CPU/MASTER_DBG: master index of the CPU io port and the debug/loader
package io_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam int          TIMEOUT_CYCLES_DEF = 15;
    localparam logic [31:0] ERR_RDATA_DEF      = 32'hDEAD_BEEF;

    localparam int MASTER_CPU = 0;
    localparam int MASTER_DBG = 1;

endpackage

// File: rtl/io_rr_pick.sv
// io_rr_pick: combinational round-robin grant for two masters.
//   req[1:0]   : per-master request
//   rr_ptr     : master that wins when both request
//   grant[1:0] : one-hot grant, all zero when nobody requests
module io_rr_pick
    import io_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant[MASTER_CPU] = 1'b1;
            2'b10:   grant[MASTER_DBG] = 1'b1;
            2'b11: begin
                if (rr_ptr) grant[MASTER_DBG] = 1'b1;
                else        grant[MASTER_CPU] = 1'b1;
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: arbitrates two masters (CPU io port, debug/loader) onto one
// IO bus with a bus_ready wait limit. All outputs are registered.
//   clk, rst_n             : clock, async active-low reset
//   m_req/m_we[1:0]        : per-master request and write flag
//   m_addr/m_wdata[63:0]   : master i uses bits [32i+31:32i]
//   m_ack/m_err[1:0]       : one-cycle completion pulse and timeout flag
//   m_rdata[31:0]          : shared read data, valid with an m_ack bit
//   bus_address, bus_write_value, bus_write_en, bus_read_en : IO bus request
//   bus_read_value, bus_ready                              : IO bus response
//
// state  | meaning
// IDLE   | waiting for a request; grant and latch on any m_req
// ACCESS | one strobe high, waiting for bus_ready or the wait limit
// RESP   | strobes low; ack/err to the owner issued on leaving this state
module io_bus_arbiter
    import io_bus_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  m_req,
    input  logic [1:0]  m_we,
    input  logic [63:0] m_addr,
    input  logic [63:0] m_wdata,
    output logic [1:0]  m_ack,
    output logic [1:0]  m_err,
    output logic [31:0] m_rdata,
    output logic [31:0] bus_address,
    output logic [31:0] bus_write_value,
    output logic        bus_write_en,
    output logic        bus_read_en,
    input  logic [31:0] bus_read_value,
    input  logic        bus_ready
);

    localparam logic [7:0] TO_CNT = TIMEOUT_CYCLES[7:0];

    state_t      state_q, state_d;
    logic        rr_ptr_q;
    logic        owner_q;
    logic        we_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [7:0]  wait_cnt_q;

    logic [1:0]  grant;
    logic        sel_dbg;
    logic        sel_we;
    logic        acc_done;
    logic        acc_timeout;

    io_rr_pick u_rr_pick (
        .req    (m_req),
        .rr_ptr (rr_ptr_q),
        .grant  (grant)
    );

    always_comb begin
        sel_dbg     = (grant == 2'b10);
        sel_we      = sel_dbg ? m_we[1] : m_we[0];
        acc_done    = 1'b0;
        acc_timeout = 1'b0;
        state_d     = state_q;
        case (state_q)
            ST_IDLE: begin
                if (m_req != 2'b00) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // a ready on the limit cycle completes normally
                if (bus_ready) begin
                    acc_done = 1'b1;
                    state_d  = ST_RESP;
                end else if (wait_cnt_q == TO_CNT) begin
                    acc_timeout = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            rr_ptr_q        <= 1'b0;
            owner_q         <= 1'b0;
            we_q            <= 1'b0;
            err_q           <= 1'b0;
            rdata_q         <= '0;
            wait_cnt_q      <= '0;
            m_ack           <= '0;
            m_err           <= '0;
            m_rdata         <= '0;
            bus_address     <= '0;
            bus_write_value <= '0;
            bus_write_en    <= 1'b0;
            bus_read_en     <= 1'b0;
        end else begin
            state_q      <= state_d;
            m_ack        <= '0;
            m_err        <= '0;
            m_rdata      <= '0;
            bus_write_en <= 1'b0;
            bus_read_en  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (state_d == ST_ACCESS) begin
                        owner_q         <= sel_dbg;
                        we_q            <= sel_we;
                        bus_address     <= sel_dbg ? m_addr[63:32]  : m_addr[31:0];
                        bus_write_value <= sel_dbg ? m_wdata[63:32] : m_wdata[31:0];
                        bus_write_en    <= sel_we;
                        bus_read_en     <= ~sel_we;
                        wait_cnt_q      <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (acc_done) begin
                        err_q   <= 1'b0;
                        rdata_q <= we_q ? 32'h0 : bus_read_value;
                    end else if (acc_timeout) begin
                        err_q   <= 1'b1;
                        rdata_q <= ERR_RDATA;
                    end else begin
                        wait_cnt_q   <= wait_cnt_q + 8'd1;
                        bus_write_en <= we_q;
                        bus_read_en  <= ~we_q;
                    end
                end
                ST_RESP: begin
                    m_ack[owner_q] <= 1'b1;
                    m_err[owner_q] <= err_q;
                    m_rdata        <= rdata_q;
                    rr_ptr_q       <= ~owner_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
module tb_io_bus_arbiter;

    localparam int          TO  = 15;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst_n;
    logic [1:0]  m_req;
    logic [1:0]  m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [1:0]  m_ack;
    logic [1:0]  m_err;
    logic [31:0] m_rdata;
    logic [31:0] bus_address;
    logic [31:0] bus_write_value;
    logic        bus_write_en;
    logic        bus_read_en;
    logic [31:0] bus_read_value;
    logic        bus_ready;

    int n_cmp;
    int n_bad;
    int rr_m;   // reference round-robin pointer

    io_bus_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .m_req           (m_req),
        .m_we            (m_we),
        .m_addr          (m_addr),
        .m_wdata         (m_wdata),
        .m_ack           (m_ack),
        .m_err           (m_err),
        .m_rdata         (m_rdata),
        .bus_address     (bus_address),
        .bus_write_value (bus_write_value),
        .bus_write_en    (bus_write_en),
        .bus_read_en     (bus_read_en),
        .bus_read_value  (bus_read_value),
        .bus_ready       (bus_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction from the reference point of view. Starts just after an
    // edge with the arbiter idle; the next edge is the grant edge. w is the
    // number of not-ready strobe cycles before the slave answers. rv != 0 fixes
    // the read data, otherwise it is randomised every cycle.
    task automatic run_txn(input logic [1:0] req, input logic [1:0] we,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input int w, input bit hold, input logic [31:0] rv);
        int          win;
        logic        e_we;
        logic [31:0] e_addr, e_wd, e_rdata, rec;
        int          e_cyc, ack_c, nstr;
        bit          e_err, overlap;
        logic [1:0]  e_ack, e_errv, ack_v, err_v;
        logic [31:0] rd_v;

        if (req == 2'b01)      win = 0;
        else if (req == 2'b10) win = 1;
        else                   win = rr_m;
        e_we   = we[win];
        e_addr = win ? a1 : a0;
        e_wd   = win ? d1 : d0;
        e_err  = (w > TO);
        e_cyc  = e_err ? TO + 1 : w + 1;
        e_ack  = 2'(1 << win);
        e_errv = e_err ? e_ack : 2'b00;

        m_req = req; m_we = we; m_addr = {a1, a0}; m_wdata = {d1, d0};
        bus_ready = 1'b0;
        ack_c = -1; nstr = 0; overlap = 0; rec = '0;
        ack_v = '0; err_v = '0; rd_v = '0;

        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            bus_ready      = (c == w);
            bus_read_value = (rv != 0) ? rv : $urandom;
            if (c == w) rec = bus_read_value;
            if (c == 0) begin
                n_cmp++;
                if ({bus_write_en, bus_read_en} !== {e_we, ~e_we}) begin
                    n_bad++;
                    $display("FAIL strobe_kind: got wr=%0b rd=%0b want wr=%0b", bus_write_en, bus_read_en, e_we);
                end
                n_cmp++;
                if ({bus_address, bus_write_value} !== {e_addr, e_wd}) begin
                    n_bad++;
                    $display("FAIL bus_addr_data: got %h/%h want %h/%h", bus_address, bus_write_value, e_addr, e_wd);
                end
                n_cmp++;
                if (m_ack !== 2'b00) begin
                    n_bad++;
                    $display("FAIL ack_pulse_width: got m_ack=%b at grant want 00", m_ack);
                end
                // these must be ignored once the transaction is under way
                m_addr = {$urandom, $urandom}; m_wdata = {$urandom, $urandom};
                m_we = 2'($urandom);
                if (!hold) m_req = 2'($urandom);
            end
            if (bus_write_en && bus_read_en) overlap = 1;
            if (bus_write_en || bus_read_en) nstr++;
            if (m_ack != 2'b00) begin
                ack_c = c; ack_v = m_ack; err_v = m_err; rd_v = m_rdata;
                m_req = hold ? req : 2'b00;
                break;
            end
        end

        e_rdata = e_err ? ERR : (e_we ? 32'h0 : rec);

        n_cmp++;
        if (ack_c != e_cyc + 1) begin
            n_bad++;
            $display("FAIL ack_latency: got cycle %0d want %0d", ack_c, e_cyc + 1);
        end
        n_cmp++;
        if (nstr != e_cyc || overlap) begin
            n_bad++;
            $display("FAIL strobe_cycles: got %0d overlap=%0b want %0d overlap=0", nstr, overlap, e_cyc);
        end
        n_cmp++;
        if ({ack_v, err_v} !== {e_ack, e_errv}) begin
            n_bad++;
            $display("FAIL ack_err: got ack=%b err=%b want ack=%b err=%b", ack_v, err_v, e_ack, e_errv);
        end
        n_cmp++;
        if (rd_v !== e_rdata) begin
            n_bad++;
            $display("FAIL m_rdata: got %h want %h", rd_v, e_rdata);
        end
        rr_m = 1 - win;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
        bus_read_value = '0; bus_ready = 1'b0;
        rr_m = 0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({m_ack, m_err, m_rdata, bus_address, bus_write_value, bus_write_en, bus_read_en} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ack=%b err=%b rdata=%h addr=%h wv=%h wr=%b rd=%b want all 0",
                     m_ack, m_err, m_rdata, bus_address, bus_write_value, bus_write_en, bus_read_en);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        bit seen;
        seen = 0;
        m_req = 2'b00;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (bus_write_en || bus_read_en || m_ack != 0) seen = 1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL idle_quiet: got activity with m_req=00 want none");
        end
    endtask

    task automatic test_single_read();
        run_txn(2'b01, 2'b00, 32'h0000_1000, 32'h0, 32'h0, 32'h0, 0, 0, 32'hA5A5_0001);
    endtask

    task automatic test_write_wait();
        run_txn(2'b10, 2'b10, 32'h0, 32'h0000_2004, 32'h0, 32'h0000_00FF, 3, 0, 32'h0);
    endtask

    task automatic test_contention();
        for (int i = 0; i < 4; i++)
            run_txn(2'b11, 2'($urandom), $urandom, $urandom, $urandom, $urandom,
                    $urandom_range(0, 3), (i != 3), 32'h0);
    endtask

    task automatic test_timeout();
        run_txn(2'b01, 2'b00, 32'h0000_3000, 32'h0, 32'h0, 32'h0, 100, 0, 32'h0);
        run_txn(2'b10, 2'b10, 32'h0, 32'h0000_3004, 32'h0, 32'h1234_5678, 100, 0, 32'h0);
        // ready on the limit cycle itself wins over the timeout
        run_txn(2'b01, 2'b00, 32'h0000_3008, 32'h0, 32'h0, 32'h0, TO, 0, 32'h0);
    endtask

    task automatic test_reset_mid_access();
        bit seen;
        // leave the DUT pointer at master 1 so a missing pointer reset shows
        run_txn(2'b01, 2'b01, 32'h40, 32'h0, 32'h11, 32'h0, 0, 0, 32'h0);
        m_req = 2'b01; m_we = 2'b00; m_addr = {32'h0, 32'h50}; bus_ready = 1'b0;
        @(posedge clk); #1;
        m_req = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus_write_en, bus_read_en, m_ack} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_async_strobes: got wr=%b rd=%b ack=%b want 0", bus_write_en, bus_read_en, m_ack);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rr_m = 0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (m_ack != 0 || bus_write_en || bus_read_en) seen = 1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL reset_no_ack: got activity after reset want none");
        end
        run_txn(2'b11, 2'b00, 32'h60, 32'h64, 32'h0, 32'h0, 1, 0, 32'h0);
    endtask

    task automatic test_random();
        int w;
        for (int i = 0; i < 14; i++) begin
            case ($urandom_range(0, 7))
                0:       w = TO;
                1:       w = TO + 1 + $urandom_range(0, 3);
                default: w = $urandom_range(0, 6);
            endcase
            run_txn(2'($urandom_range(1, 3)), 2'($urandom), $urandom, $urandom,
                    $urandom, $urandom, w, (i != 13) && $urandom_range(0, 1) == 1, 32'h0);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_idle();
        test_single_read();
        test_write_wait();
        test_contention();
        test_timeout();
        test_reset_mid_access();
        test_random();
        test_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
